// File: rtl/fft_pkg.sv
// Shared definitions for the radix-3 FFT stage sequencer.
// Holds the FSM state enum, default widths and per-group cycle count.
package fft_pkg;

    localparam int DEF_WIDTH = 15;
    localparam int DEF_AW    = 10;
    localparam int GRP_CYC   = 7;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        FIN
    } state_t;

endpackage

// File: rtl/r3_stage_ctrl_butterfly3.sv
// Combinational radix-3 DFT butterfly; outputs wrap at WIDTH bits.
// Twiddle sqrt(3)/2 held as a Q14 constant.
module Butterfly3 #(
    parameter int WIDTH = 15
) (
    input  logic signed [WIDTH-1:0] x0_re,
    input  logic signed [WIDTH-1:0] x0_im,
    input  logic signed [WIDTH-1:0] x1_re,
    input  logic signed [WIDTH-1:0] x1_im,
    input  logic signed [WIDTH-1:0] x2_re,
    input  logic signed [WIDTH-1:0] x2_im,
    output logic signed [WIDTH-1:0] y0_re,
    output logic signed [WIDTH-1:0] y0_im,
    output logic signed [WIDTH-1:0] y1_re,
    output logic signed [WIDTH-1:0] y1_im,
    output logic signed [WIDTH-1:0] y2_re,
    output logic signed [WIDTH-1:0] y2_im
);

    localparam int PW = WIDTH + 18;
    localparam logic signed [PW-1:0] C = 14189;

    logic signed [PW-1:0] a0r, a0i, a1r, a1i, a2r, a2i;
    logic signed [PW-1:0] sr, si, dr, di, hr, hi, pr, pi;

    assign a0r = PW'(x0_re);
    assign a0i = PW'(x0_im);
    assign a1r = PW'(x1_re);
    assign a1i = PW'(x1_im);
    assign a2r = PW'(x2_re);
    assign a2i = PW'(x2_im);

    assign sr = a1r + a2r;
    assign si = a1i + a2i;
    assign dr = a1r - a2r;
    assign di = a1i - a2i;

    // x0 - (x1+x2)/2 is common to y1 and y2
    assign hr = a0r - (sr >>> 1);
    assign hi = a0i - (si >>> 1);
    assign pr = (C * di) >>> 14;
    assign pi = (C * dr) >>> 14;

    assign y0_re = WIDTH'(a0r + sr);
    assign y0_im = WIDTH'(a0i + si);
    assign y1_re = WIDTH'(hr + pr);
    assign y1_im = WIDTH'(hi - pi);
    assign y2_re = WIDTH'(hr - pr);
    assign y2_im = WIDTH'(hi + pi);

endmodule

// File: rtl/r3_stage_ctrl.sv
// Radix-3 FFT stage sequencer: read 3, wait, write 3 per group, in place.
// Optional R3_SCALE_EN: inputs to the butterfly are shifted right by 2.
module r3_stage_ctrl
    import fft_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    m_len,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_re,
    input  logic [WIDTH-1:0] rd_im,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_re,
    output logic [WIDTH-1:0] wr_im
);

    state_t state;
    logic [AW-1:0] m;
    logic [AW-1:0] g;
    logic [1:0]    k;

    logic signed [WIDTH-1:0] x0_re, x0_im, x1_re, x1_im, x2_re, x2_im;
    logic signed [WIDTH-1:0] b0_re, b0_im, b1_re, b1_im, b2_re, b2_im;
    logic signed [WIDTH-1:0] y0_re, y0_im, y1_re, y1_im, y2_re, y2_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m       <= '0;
            g       <= '0;
            k       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            x0_re   <= '0;
            x0_im   <= '0;
            x1_re   <= '0;
            x1_im   <= '0;
            x2_re   <= '0;
            x2_im   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m <= m_len;
                        g <= '0;
                        k <= '0;
                        if (m_len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state   <= RD;
                            busy    <= 1'b1;
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                        end
                    end
                end
                RD: begin
                    // read data trails the strobe by one cycle
                    if (k == 2'd1) begin
                        x0_re <= rd_re;
                        x0_im <= rd_im;
                    end
                    if (k == 2'd2) begin
                        x1_re <= rd_re;
                        x1_im <= rd_im;
                        k     <= '0;
                        rd_en <= 1'b0;
                        state <= WAIT;
                    end else begin
                        k       <= k + 2'd1;
                        rd_addr <= rd_addr + m;
                    end
                end
                WAIT: begin
                    x2_re   <= rd_re;
                    x2_im   <= rd_im;
                    wr_en   <= 1'b1;
                    wr_addr <= g;
                    state   <= WR;
                end
                WR: begin
                    if (k == 2'd2) begin
                        k     <= '0;
                        wr_en <= 1'b0;
                        if (g == m - AW'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            g       <= g + AW'(1);
                            rd_en   <= 1'b1;
                            rd_addr <= g + AW'(1);
                            state   <= RD;
                        end
                    end else begin
                        k       <= k + 2'd1;
                        wr_addr <= wr_addr + m;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef R3_SCALE_EN
    assign b0_re = x0_re >>> 2;
    assign b0_im = x0_im >>> 2;
    assign b1_re = x1_re >>> 2;
    assign b1_im = x1_im >>> 2;
    assign b2_re = x2_re >>> 2;
    assign b2_im = x2_im >>> 2;
`else
    assign b0_re = x0_re;
    assign b0_im = x0_im;
    assign b1_re = x1_re;
    assign b1_im = x1_im;
    assign b2_re = x2_re;
    assign b2_im = x2_im;
`endif

    Butterfly3 #(
        .WIDTH(WIDTH)
    ) u_bfly (
        .x0_re(b0_re),
        .x0_im(b0_im),
        .x1_re(b1_re),
        .x1_im(b1_im),
        .x2_re(b2_re),
        .x2_im(b2_im),
        .y0_re(y0_re),
        .y0_im(y0_im),
        .y1_re(y1_re),
        .y1_im(y1_im),
        .y2_re(y2_re),
        .y2_im(y2_im)
    );

    always_comb begin
        wr_re = '0;
        wr_im = '0;
        if (wr_en) begin
            case (k)
                2'd0: begin
                    wr_re = y0_re;
                    wr_im = y0_im;
                end
                2'd1: begin
                    wr_re = y1_re;
                    wr_im = y1_im;
                end
                default: begin
                    wr_re = y2_re;
                    wr_im = y2_im;
                end
            endcase
        end
    end

endmodule
